// File: rtl/pim_pkg.sv
// Shared definitions for the PIM macro controller: scheduler state encoding
// and default geometry constants.
package pim_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HRD,
        S_HRSP,
        S_HWR,
        S_MISSUE,
        S_MWAIT
    } state_t;

    localparam int unsigned PDEPTH_DEF    = 256;
    localparam int unsigned ACC_WIDTH_DEF = 48;

endpackage

// File: rtl/pim_rr_arb2.sv
// Two-requester arbiter (host vs. MAC pass) with alternating priority when
// both request; a lone requester always wins.
module pim_rr_arb2 (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic req_host,
    input  logic req_pass,
    output logic grant_host,
    output logic grant_pass
);

    logic last_was_host;

    always_comb begin
        grant_host = en && req_host && (!req_pass || !last_was_host);
        grant_pass = en && req_pass && (!req_host || last_was_host);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_was_host <= 1'b0;
        end else if (grant_host || grant_pass) begin
            last_was_host <= grant_host;
        end
    end

endmodule

// File: rtl/pim_mac_sched.sv
// Shares the PIM macro port between host word accesses and multi-pass MAC
// jobs, accumulating per-pass results into a wide signed sum.
module pim_mac_sched
    import pim_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned ADDR_WIDTH  = 6,
    parameter int unsigned PDEPTH      = PDEPTH_DEF,
    parameter int unsigned ACC_WIDTH   = ACC_WIDTH_DEF,
    parameter int unsigned MAC_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  host_req_valid,
    output logic                  host_req_ready,
    input  logic                  host_req_we,
    input  logic [ADDR_WIDTH-1:0] host_req_addr,
    input  logic [DATA_WIDTH-1:0] host_req_wdata,
    output logic                  host_rsp_valid,
    output logic [DATA_WIDTH-1:0] host_rsp_rdata,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [PDEPTH-1:0]     job_rwl,
    input  logic [7:0]            job_passes,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [ACC_WIDTH-1:0]  res_data,
    output logic [ADDR_WIDTH-1:0] pim_addr,
    output logic [DATA_WIDTH-1:0] pim_d,
    output logic                  pim_w_en,
    output logic                  pim_p_en,
    output logic [PDEPTH-1:0]     pim_rwl,
    input  logic [DATA_WIDTH-1:0] pim_q,
    input  logic [DATA_WIDTH-1:0] pim_mac_out
);

    localparam int unsigned CW = (MAC_LATENCY > 1) ? $clog2(MAC_LATENCY) : 1;

    state_t                state, next_state;
    logic                  job_active;
    logic                  grant_host, grant_pass;
    logic [PDEPTH-1:0]     rwl_reg;
    logic [7:0]            passes_left;
    logic [ACC_WIDTH-1:0]  acc, acc_sum;
    logic [CW-1:0]         lat_cnt;

    pim_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .en        (state == S_IDLE && !rst),
        .req_host  (host_req_valid),
        .req_pass  (job_active),
        .grant_host(grant_host),
        .grant_pass(grant_pass)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state     = state;
        host_req_ready = 1'b0;
        job_ready      = 1'b0;
        acc_sum        = acc + ACC_WIDTH'($signed(pim_mac_out));
        case (state)
            S_IDLE: begin
                // Readies are forced low while reset is held.
                job_ready      = !rst && !job_active && !res_valid;
                host_req_ready = grant_host;
                if (grant_host)      next_state = host_req_we ? S_HWR : S_HRD;
                else if (grant_pass) next_state = S_MISSUE;
            end
            S_HRD:    next_state = S_HRSP;
            S_HRSP:   next_state = S_IDLE;
            S_HWR:    next_state = S_IDLE;
            S_MISSUE: next_state = S_MWAIT;
            S_MWAIT:  if (lat_cnt == '0) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            host_rsp_valid <= 1'b0;
            host_rsp_rdata <= '0;
            res_valid      <= 1'b0;
            res_data       <= '0;
            pim_addr       <= '0;
            pim_d          <= '0;
            pim_w_en       <= 1'b0;
            pim_p_en       <= 1'b0;
            pim_rwl        <= '0;
            acc            <= '0;
            rwl_reg        <= '0;
            passes_left    <= '0;
            job_active     <= 1'b0;
            lat_cnt        <= '0;
        end else begin
            pim_w_en       <= 1'b0;
            pim_p_en       <= 1'b0;
            pim_rwl        <= '0;
            host_rsp_valid <= 1'b0;

            if (job_ready && job_valid) begin
                rwl_reg     <= job_rwl;
                passes_left <= (job_passes == 8'd0) ? 8'd1 : job_passes;
                acc         <= '0;
                job_active  <= 1'b1;
            end

            if (host_req_ready) begin
                pim_addr <= host_req_addr;
                if (host_req_we) begin
                    pim_d    <= host_req_wdata;
                    pim_w_en <= 1'b1;
                end
            end

            if (grant_pass) begin
                pim_p_en <= 1'b1;
                pim_rwl  <= rwl_reg;
            end

            if (state == S_MISSUE) lat_cnt <= CW'(MAC_LATENCY - 1);

            if (state == S_MWAIT) begin
                if (lat_cnt == '0) begin
                    acc         <= acc_sum;
                    rwl_reg     <= {rwl_reg[PDEPTH-2:0], rwl_reg[PDEPTH-1]};
                    passes_left <= passes_left - 8'd1;
                    if (passes_left == 8'd1) begin
                        res_valid  <= 1'b1;
                        res_data   <= acc_sum;
                        job_active <= 1'b0;
                    end
                end else begin
                    lat_cnt <= lat_cnt - CW'(1);
                end
            end

            if (state == S_HRSP) begin
                host_rsp_valid <= 1'b1;
                host_rsp_rdata <= pim_q;
            end

            if (res_valid && res_ready) res_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pim_mac_sched.sv
// Scoreboard bench for pim_mac_sched: macro memory/MAC models, host and job
// stimulus, plus a 33-bit accumulator instance for wrap behaviour.
module tb_pim_mac_sched;

    localparam int PD = 256;
    localparam logic [31:0] JUNK = 32'h5A5A_5A5A;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          host_req_valid = 1'b0, host_req_ready, host_req_we = 1'b0;
    logic [5:0]    host_req_addr = '0;
    logic [31:0]   host_req_wdata = '0;
    logic          host_rsp_valid;
    logic [31:0]   host_rsp_rdata;
    logic          job_valid = 1'b0, job_ready;
    logic [PD-1:0] job_rwl = '0;
    logic [7:0]    job_passes = '0;
    logic          res_valid, res_ready = 1'b0;
    logic [47:0]   res_data;
    logic [5:0]    pim_addr;
    logic [31:0]   pim_d, pim_q, pim_mac_out;
    logic          pim_w_en, pim_p_en;
    logic [PD-1:0] pim_rwl;

    logic          b_job_valid = 1'b0, b_job_ready, b_res_valid, b_res_ready = 1'b0;
    logic [PD-1:0] b_job_rwl = '0;
    logic [7:0]    b_job_passes = '0;
    logic [32:0]   b_res_data;
    logic          b_host_req_ready, b_host_rsp_valid, b_w_en, b_p_en;
    logic [31:0]   b_host_rsp_rdata, b_pim_d, b_mac_out;
    logic [5:0]    b_pim_addr;
    logic [PD-1:0] b_pim_rwl;
    logic [31:0]   b_mac_val = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int pen_count = 0;
    int mac_base = 0;
    int mac_n = 0;
    logic [31:0]   mac_tab [8];
    logic [31:0]   mem [64];
    logic [PD-1:0] rwl_log [$];
    logic [31:0]   rsp_q [$];
    logic [47:0]   res_q [$];
    logic [32:0]   b_res_q [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Macro model: one-cycle read latency, MAC value valid only at p_en+1.
    always @(posedge clk) begin
        if (pim_w_en) mem[pim_addr] <= pim_d;
        pim_q <= mem[pim_addr];
        if (pim_p_en) begin
            pen_count <= pen_count + 1;
            rwl_log.push_back(pim_rwl);
            pim_mac_out <= (pen_count - mac_base < mac_n) ? mac_tab[pen_count - mac_base] : JUNK;
        end else begin
            pim_mac_out <= JUNK;
        end
        b_mac_out <= b_p_en ? b_mac_val : JUNK;
    end

    pim_mac_sched #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .PDEPTH(PD), .ACC_WIDTH(48), .MAC_LATENCY(1)) u_dut (
        .clk(clk), .rst(rst),
        .host_req_valid(host_req_valid), .host_req_ready(host_req_ready),
        .host_req_we(host_req_we), .host_req_addr(host_req_addr), .host_req_wdata(host_req_wdata),
        .host_rsp_valid(host_rsp_valid), .host_rsp_rdata(host_rsp_rdata),
        .job_valid(job_valid), .job_ready(job_ready), .job_rwl(job_rwl), .job_passes(job_passes),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .pim_addr(pim_addr), .pim_d(pim_d), .pim_w_en(pim_w_en), .pim_p_en(pim_p_en),
        .pim_rwl(pim_rwl), .pim_q(pim_q), .pim_mac_out(pim_mac_out)
    );

    pim_mac_sched #(.ACC_WIDTH(33)) u_dut33 (
        .clk(clk), .rst(rst),
        .host_req_valid(1'b0), .host_req_ready(b_host_req_ready),
        .host_req_we(1'b0), .host_req_addr(6'd0), .host_req_wdata(32'd0),
        .host_rsp_valid(b_host_rsp_valid), .host_rsp_rdata(b_host_rsp_rdata),
        .job_valid(b_job_valid), .job_ready(b_job_ready), .job_rwl(b_job_rwl), .job_passes(b_job_passes),
        .res_valid(b_res_valid), .res_ready(b_res_ready), .res_data(b_res_data),
        .pim_addr(b_pim_addr), .pim_d(b_pim_d), .pim_w_en(b_w_en), .pim_p_en(b_p_en),
        .pim_rwl(b_pim_rwl), .pim_q(32'd0), .pim_mac_out(b_mac_out)
    );

    task automatic host_issue(input logic we, input logic [5:0] a, input logic [31:0] d, output bit ok);
        @(posedge clk); #1;
        host_req_valid = 1'b1; host_req_we = we; host_req_addr = a; host_req_wdata = d;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (host_req_ready) begin ok = 1'b1; break; end
        end
        @(posedge clk); #1;
        host_req_valid = 1'b0; host_req_we = 1'b0;
    endtask

    task automatic job_issue(input logic [PD-1:0] rwl, input logic [7:0] np, output bit ok, output int t);
        @(posedge clk); #1;
        job_valid = 1'b1; job_rwl = rwl; job_passes = np;
        ok = 1'b0; t = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (job_ready) begin ok = 1'b1; t = cyc; break; end
        end
        @(posedge clk); #1;
        job_valid = 1'b0;
    endtask

    task automatic wait_res(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (res_valid) begin ok = 1'b1; break; end
        end
    endtask

    task automatic consume_res();
        @(posedge clk); #1; res_ready = 1'b1;
        @(posedge clk); #1; res_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({host_req_ready, job_ready, res_valid, host_rsp_valid, pim_w_en, pim_p_en, b_job_ready} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 0", {host_req_ready, job_ready, res_valid, host_rsp_valid, pim_w_en, pim_p_en, b_job_ready});
        end
        checks++;
        if ((res_data !== '0) || (pim_rwl !== '0) || (pim_addr !== '0) || (pim_d !== '0) || (host_rsp_rdata !== '0)) begin
            errors++; $display("FAIL reset_data got res %h addr %h d %h rdata %h want 0", res_data, pim_addr, pim_d, host_rsp_rdata);
        end
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({job_ready, host_req_ready} !== 2'b10) begin
            errors++; $display("FAIL reset_release got %b want 10", {job_ready, host_req_ready});
        end
    endtask

    task automatic test_write_read();
        logic [5:0]  ta [3];
        logic [31:0] td [3];
        logic [31:0] e32;
        logic        v1, v2, v3;
        bit ok;
        ta[0] = 6'd5;  td[0] = 32'hDEAD_BEEF;
        ta[1] = 6'd63; td[1] = 32'h0000_0001;
        ta[2] = 6'd0;  td[2] = 32'hFFFF_FFFF;
        for (int i = 0; i < 3; i++) begin
            host_issue(1'b1, ta[i], td[i], ok);
            @(negedge clk);
            checks++;
            if (!ok || pim_w_en !== 1'b1 || pim_p_en !== 1'b0 || pim_addr !== ta[i] || pim_d !== td[i]) begin
                errors++; $display("FAIL wr_pulse%0d got ok %0d w_en %b addr %h d %h want 1 1 %h %h", i, ok, pim_w_en, pim_addr, pim_d, ta[i], td[i]);
            end
            @(negedge clk);
            checks++;
            if (pim_w_en !== 1'b0) begin
                errors++; $display("FAIL wr_single%0d got w_en %b want 0", i, pim_w_en);
            end
        end
        for (int i = 0; i < 3; i++) begin
            rsp_q.push_back(td[i]);
            host_issue(1'b0, ta[i], 32'd0, ok);
            @(negedge clk); v1 = host_rsp_valid;
            @(negedge clk); v2 = host_rsp_valid;
            @(negedge clk); v3 = host_rsp_valid;
            e32 = rsp_q.pop_front();
            checks++;
            if (!ok || {v1, v2, v3} !== 3'b001 || host_rsp_rdata !== e32) begin
                errors++; $display("FAIL rd%0d got ok %0d valid %b data %h want 1 001 %h", i, ok, {v1, v2, v3}, host_rsp_rdata, e32);
            end
        end
    endtask

    task automatic test_job3();
        logic [47:0]   e48;
        logic [31:0]   e32;
        logic [PD-1:0] er;
        bit ok, ok2, hold_ok, rsp_seen;
        int t, rb, pb;
        rb = rwl_log.size(); pb = pen_count;
        mac_tab[0] = 32'd10; mac_tab[1] = 32'hFFFF_FFFC; mac_tab[2] = 32'd7;
        mac_base = pen_count; mac_n = 3;
        res_q.push_back(48'd13);
        job_issue(256'd1, 8'd3, ok, t);
        wait_res(60, ok2);
        checks++;
        if (!ok || !ok2 || cyc - t != 10) begin
            errors++; $display("FAIL job3_latency got ok %0d/%0d delay %0d want 10", ok, ok2, cyc - t);
        end
        e48 = res_q.pop_front();
        checks++;
        if (res_data !== e48) begin
            errors++; $display("FAIL job3_data got %h want %h", res_data, e48);
        end
        // Host reads are still served while the result waits.
        rsp_q.push_back(32'hDEAD_BEEF);
        hold_ok = 1'b1; rsp_seen = 1'b0;
        host_issue(1'b0, 6'd5, 32'd0, ok);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || job_ready !== 1'b0) hold_ok = 1'b0;
            if (host_rsp_valid) begin
                rsp_seen = 1'b1;
                e32 = rsp_q.pop_front();
                if (host_rsp_rdata !== e32) hold_ok = 1'b0;
            end
        end
        checks++;
        if (!ok || !hold_ok || !rsp_seen) begin
            errors++; $display("FAIL job3_hold got ok %0d hold %0d rsp %0d want 1 1 1", ok, hold_ok, rsp_seen);
        end
        consume_res();
        @(negedge clk);
        checks++;
        if ({res_valid, job_ready} !== 2'b01) begin
            errors++; $display("FAIL job3_consume got %b want 01", {res_valid, job_ready});
        end
        ok = (rwl_log.size() - rb == 3) && (pen_count - pb == 3);
        er = 256'd1;
        for (int i = 0; i < 3; i++) begin
            if (ok && rwl_log[rb + i] !== er) ok = 1'b0;
            er = er << 1;
        end
        checks++;
        if (!ok) begin
            errors++; $display("FAIL job3_rwl got pulses %0d first %h want 3 pulses 1,2,4", pen_count - pb, (rwl_log.size() > rb) ? rwl_log[rb] : '0);
        end
    endtask

    task automatic test_passes_zero();
        logic [PD-1:0] top;
        logic [47:0]   e48;
        bit ok, ok2;
        int t, rb, pb;
        top = '0; top[PD-1] = 1'b1;
        rb = rwl_log.size(); pb = pen_count;
        mac_tab[0] = 32'hFFFF_FF85; mac_base = pen_count; mac_n = 1;
        res_q.push_back(48'hFFFF_FFFF_FF85);
        job_issue(top, 8'd0, ok, t);
        wait_res(40, ok2);
        e48 = res_q.pop_front();
        checks++;
        if (!ok || !ok2 || cyc - t != 4 || res_data !== e48) begin
            errors++; $display("FAIL pass0_data got ok %0d/%0d delay %0d data %h want 4 %h", ok, ok2, cyc - t, res_data, e48);
        end
        consume_res();
        repeat (5) @(negedge clk);
        checks++;
        if (pen_count - pb != 1 || rwl_log.size() - rb != 1 || rwl_log[rb] !== top) begin
            errors++; $display("FAIL pass0_pulses got %0d want 1", pen_count - pb);
        end
    endtask

    task automatic test_interleave();
        bit glog [$];
        bit stop, both, ok, ok2, rsp_err;
        int t, npass;
        logic [31:0] e32;
        logic [47:0] e48;
        stop = 1'b0; both = 1'b0; rsp_err = 1'b0; ok = 1'b0; ok2 = 1'b0;
        mac_tab[0] = 32'd1; mac_tab[1] = 32'd2; mac_tab[2] = 32'd3; mac_tab[3] = 32'd4;
        mac_base = pen_count; mac_n = 4;
        res_q.push_back(48'd10);
        fork
            begin
                @(posedge clk); #1;
                host_req_valid = 1'b1; host_req_we = 1'b0; host_req_addr = 6'd5;
                for (int i = 0; i < 400; i++) begin
                    @(negedge clk);
                    if (stop) host_req_valid = 1'b0;
                    if (host_req_ready) begin rsp_q.push_back(32'hDEAD_BEEF); glog.push_back(1'b1); end
                    if (pim_p_en) glog.push_back(1'b0);
                    if (pim_w_en && pim_p_en) both = 1'b1;
                    if (host_rsp_valid) begin
                        if (rsp_q.size() == 0) rsp_err = 1'b1;
                        else begin
                            e32 = rsp_q.pop_front();
                            if (host_rsp_rdata !== e32) rsp_err = 1'b1;
                        end
                    end
                    if (stop && i > 0 && rsp_q.size() == 0 && !host_req_valid) break;
                end
                host_req_valid = 1'b0;
            end
            begin
                job_issue(256'd1, 8'd4, ok, t);
                wait_res(200, ok2);
                stop = 1'b1;
            end
        join
        e48 = res_q.pop_front();
        checks++;
        if (!ok || !ok2 || res_data !== e48) begin
            errors++; $display("FAIL ilv_data got ok %0d/%0d data %h want %h", ok, ok2, res_data, e48);
        end
        consume_res();
        checks++;
        if (rsp_err || rsp_q.size() != 0) begin
            errors++; $display("FAIL ilv_rsp got err %0d pending %0d want 0 0", rsp_err, rsp_q.size());
        end
        ok = (glog.size() >= 8);
        npass = 0;
        for (int i = 0; i < glog.size(); i++) begin
            if (glog[i] == 1'b0) npass++;
            if (i < 8 && glog[i] != (i % 2 == 0)) ok = 1'b0;
        end
        checks++;
        if (!ok || npass != 4) begin
            errors++; $display("FAIL ilv_alternate got len %0d passes %0d want HPHPHPHP 4", glog.size(), npass);
        end
        checks++;
        if (both) begin
            errors++; $display("FAIL ilv_exclusive got w_en&p_en 1 want 0");
        end
    endtask

    task automatic test_acc33();
        logic [31:0] tv [4];
        logic [7:0]  tn [4];
        logic [32:0] te [4];
        logic [32:0] e33;
        bit ok, ok2;
        tv[0] = 32'h7FFF_FFFF; tn[0] = 8'd2; te[0] = 33'h0_FFFF_FFFE;
        tv[1] = 32'h7FFF_FFFF; tn[1] = 8'd3; te[1] = 33'h1_7FFF_FFFD;
        tv[2] = 32'h8000_0000; tn[2] = 8'd2; te[2] = 33'h1_0000_0000;
        tv[3] = 32'h8000_0000; tn[3] = 8'd3; te[3] = 33'h0_8000_0000;
        for (int i = 0; i < 4; i++) begin
            b_mac_val = tv[i];
            b_res_q.push_back(te[i]);
            @(posedge clk); #1;
            b_job_valid = 1'b1; b_job_rwl = 256'd1; b_job_passes = tn[i];
            ok = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (b_job_ready) begin ok = 1'b1; break; end
            end
            @(posedge clk); #1; b_job_valid = 1'b0;
            ok2 = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (b_res_valid) begin ok2 = 1'b1; break; end
            end
            e33 = b_res_q.pop_front();
            checks++;
            if (!ok || !ok2 || b_res_data !== e33) begin
                errors++; $display("FAIL acc33_%0d got ok %0d/%0d data %h want %h", i, ok, ok2, b_res_data, e33);
            end
            @(posedge clk); #1; b_res_ready = 1'b1;
            @(posedge clk); #1; b_res_ready = 1'b0;
        end
    endtask

    task automatic test_reset_mid();
        bit ok, seen;
        int t;
        mac_tab[0] = 32'd5; mac_tab[1] = 32'd5; mac_base = pen_count; mac_n = 2;
        job_issue(256'd1, 8'd2, ok, t);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (pim_p_en) begin seen = 1'b1; break; end
        end
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (!ok || !seen || {host_req_ready, job_ready, res_valid, host_rsp_valid, pim_w_en, pim_p_en} !== 6'b0 ||
            res_data !== '0 || pim_rwl !== '0 || pim_addr !== '0 || pim_d !== '0 || host_rsp_rdata !== '0) begin
            errors++; $display("FAIL rstmid_outputs got ok %0d pen %0d res %h addr %h rdata %h want all 0", ok, seen, res_data, pim_addr, host_rsp_rdata);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        mac_n = 0;
        @(negedge clk);
        checks++;
        if (job_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_ready got %b want 1", job_ready);
        end
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (res_valid || pim_p_en) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++; $display("FAIL rstmid_quiet got activity 1 want 0");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_job3();
        test_passes_zero();
        test_interleave();
        test_acc33();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
